// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, baud presets and frame bit levels.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

    // Clock cycles per bit with a 50 MHz system clock.
    localparam int CLKS_PER_BIT_9600   = 5208;
    localparam int CLKS_PER_BIT_115200 = 434;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for a single asynchronous input; reset value is chosen
// so the output reads as the input's idle level while in reset.
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a half-bit start check, LSB first,
// one-cycle newData / frameError strobes, and a BREAK state for a held-low line.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 8,
    parameter int STATE_SIZE    = 3,
    parameter int CLKS_PER_BIT  = CLKS_PER_BIT_9600,
    parameter int COUNT_WIDTH   = 16
) (
    input  logic                     UART_RX_CLOCK_50,
    input  logic                     UART_RX_RESET_InLow,
    input  logic                     UART_RX_rx_In,
    output logic [DATAWIDTH_BUS-1:0] UART_RX_data_Out,
    output logic                     UART_RX_newData_Out,
    output logic                     UART_RX_frameError_Out,
    output logic                     UART_RX_rxBusy_Out,
    output logic [STATE_SIZE-1:0]    UART_RX_state_Out
);

    localparam int IDX_W = $clog2(DATAWIDTH_BUS + 1);
    localparam logic [COUNT_WIDTH-1:0] HALF_TC = COUNT_WIDTH'(CLKS_PER_BIT / 2 - 1);
    localparam logic [COUNT_WIDTH-1:0] BIT_TC  = COUNT_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(DATAWIDTH_BUS - 1);

    logic rx_sync;

    uart_rx_sync #(
        .RESET_VAL(STOP_BIT)
    ) u_sync (
        .clk_i  (UART_RX_CLOCK_50),
        .rst_ni (UART_RX_RESET_InLow),
        .async_i(UART_RX_rx_In),
        .sync_o (rx_sync)
    );

    uart_state_e              state_q;
    logic [COUNT_WIDTH-1:0]   cnt_q;
    logic [COUNT_WIDTH-1:0]   cnt_d;
    logic [IDX_W-1:0]         bit_idx_q;
    logic [DATAWIDTH_BUS-1:0] shift_q;
    logic [DATAWIDTH_BUS-1:0] data_q;
    logic                     new_data_q;
    logic                     frame_err_q;

    assign cnt_d = cnt_q + COUNT_WIDTH'(1);

    always_ff @(posedge UART_RX_CLOCK_50 or negedge UART_RX_RESET_InLow) begin
        if (!UART_RX_RESET_InLow) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_sync == START_BIT) begin
                        state_q <= ST_START;
                        cnt_q   <= '0;
                    end
                end
                ST_START: begin
                    // A start bit must still be low half a bit in, else it was a glitch.
                    if (cnt_q == HALF_TC) begin
                        if (rx_sync == START_BIT) begin
                            state_q   <= ST_DATA;
                            cnt_q     <= '0;
                            bit_idx_q <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_TC) begin
                        cnt_q     <= '0;
                        shift_q   <= {rx_sync, shift_q[DATAWIDTH_BUS-1:1]};
                        bit_idx_q <= bit_idx_q + IDX_W'(1);
                        if (bit_idx_q == LAST_IDX) begin
                            state_q <= ST_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_STOP: begin
                    // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
                    if (cnt_q == BIT_TC) begin
                        cnt_q <= '0;
                        if (rx_sync == STOP_BIT) begin
                            data_q     <= shift_q;
                            new_data_q <= 1'b1;
                            state_q    <= ST_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_BREAK: begin
                    if (rx_sync == STOP_BIT) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign UART_RX_data_Out       = data_q;
    assign UART_RX_newData_Out    = new_data_q;
    assign UART_RX_frameError_Out = frame_err_q;
    assign UART_RX_rxBusy_Out     = (state_q != ST_IDLE);
    assign UART_RX_state_Out      = STATE_SIZE'(state_q);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: framing, glitch rejection,
// framing error with break, back-to-back frames and mid-frame reset.
module tb_uart_rx;

    localparam int CLKS = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b0;
    logic [7:0] data;
    logic       nd;
    logic       fe;
    logic       busy;
    logic [2:0] st;

    uart_rx #(
        .DATAWIDTH_BUS(8),
        .STATE_SIZE   (3),
        .CLKS_PER_BIT (CLKS),
        .COUNT_WIDTH  (16)
    ) dut (
        .UART_RX_CLOCK_50      (clk),
        .UART_RX_RESET_InLow   (rst_n),
        .UART_RX_rx_In         (rx),
        .UART_RX_data_Out      (data),
        .UART_RX_newData_Out   (nd),
        .UART_RX_frameError_Out(fe),
        .UART_RX_rxBusy_Out    (busy),
        .UART_RX_state_Out     (st)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    // Output monitor
    int         nd_cnt   = 0;
    int         fe_cnt   = 0;
    int         both_cnt = 0;
    int         nd_cyc_q[$];
    logic [7:0] nd_data_q[$];
    logic [7:0] exp_q[$];
    int         start_cyc;

    always @(negedge clk) begin
        if (nd) begin
            nd_cnt++;
            nd_cyc_q.push_back(cyc);
            nd_data_q.push_back(data);
        end
        if (fe) fe_cnt++;
        if (nd && fe) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Driver: called at a negedge, returns at the negedge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx = stop;
        repeat (CLKS) @(negedge clk);
        if (stop) exp_q.push_back(b);
    endtask

    // Scoreboard drain
    task automatic check_frames();
        while (nd_data_q.size() > 0 && exp_q.size() > 0)
            check("rx_byte", 32'(nd_data_q.pop_front()), 32'(exp_q.pop_front()));
        check("sb_leftover", nd_data_q.size() + exp_q.size(), 0);
    endtask

    int nd0, fe0, lat, gap, t_first;

    initial begin
        // Reset with the line held low
        rst_n = 1'b0;
        rx    = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_data", 32'(data), 32'h00);
        check("rst_nd", 32'(nd), 0);
        check("rst_fe", 32'(fe), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(st), 0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        check("idle_state", 32'(st), 0);
        check("idle_busy", 32'(busy), 0);
        check("idle_nd", nd_cnt, 0);

        // Good frame 0xA5
        nd0 = nd_cnt; fe0 = fe_cnt;
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        check("a5_nd_cnt", nd_cnt - nd0, 1);
        check("a5_fe_cnt", fe_cnt - fe0, 0);
        check("a5_data", 32'(data), 32'hA5);
        lat = nd_cyc_q[nd_cyc_q.size()-1] - start_cyc;
        check("a5_latency_ok", 32'(lat >= 153 && lat <= 157), 1);
        check_frames();

        // Glitch: 4 low cycles
        nd0 = nd_cnt; fe0 = fe_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        check("glitch_busy_hi", 32'(busy), 1);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_busy_lo", 32'(busy), 0);
        check("glitch_nd", nd_cnt - nd0, 0);
        check("glitch_fe", fe_cnt - fe0, 0);
        check("glitch_data", 32'(data), 32'hA5);

        // Framing error then held-low break
        nd0 = nd_cnt; fe0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (60) @(negedge clk);
        check("ferr_fe_cnt", fe_cnt - fe0, 1);
        check("ferr_nd_cnt", nd_cnt - nd0, 0);
        check("ferr_data", 32'(data), 32'hA5);
        check("ferr_busy", 32'(busy), 1);
        check("ferr_state", 32'(st), 4);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("break_exit_busy", 32'(busy), 0);
        nd0 = nd_cnt;
        send_frame(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        check("zero_nd_cnt", nd_cnt - nd0, 1);
        check("zero_data", 32'(data), 32'h00);
        check_frames();

        // Back-to-back 0x55 then 0xFF with no idle gap
        nd0 = nd_cnt;
        send_frame(8'h55, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        check("b2b_nd_cnt", nd_cnt - nd0, 2);
        t_first = nd_cyc_q[nd_cyc_q.size()-2];
        gap = nd_cyc_q[nd_cyc_q.size()-1] - t_first;
        check("b2b_gap_ok", 32'(gap >= 159 && gap <= 161), 1);
        check("b2b_data", 32'(data), 32'hFF);
        check_frames();

        // Reset during data bit 3 of 0x81
        rx = 1'b0;
        repeat (CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (CLKS) @(negedge clk);
        rx = 1'b0;
        repeat (2 * CLKS) @(negedge clk);
        repeat (CLKS / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data", 32'(data), 32'h00);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_state", 32'(st), 0);
        check("midrst_nd", 32'(nd), 0);
        check("midrst_fe", 32'(fe), 0);
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        nd0 = nd_cnt; fe0 = fe_cnt;
        send_frame(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        check("post_rst_nd_cnt", nd_cnt - nd0, 1);
        check("post_rst_fe_cnt", fe_cnt - fe0, 0);
        check("post_rst_data", 32'(data), 32'h5A);
        check_frames();

        check("nd_fe_exclusive", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
